dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, storage depth in 32-bit words; power of two.
REQ-002 SHALL have parameter LATENCY, default 1, cycles from request acceptance to resp_valid; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port memreq_addr, input, 32, byte address.
REQ-006 SHALL have port memreq_write_enable, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port memreq_write_data, input, 32, store data, right-aligned.
REQ-008 SHALL have port memreq_data_width, input, 3, funct3-style width code.
REQ-009 SHALL have port memreq_ready, input, 1, request strobe from initiator.
REQ-010 SHALL have port memresp_data_out, output, 32, load result.
REQ-011 SHALL have port memresp_valid, output, 1, one-cycle response/acknowledge pulse.

Function
REQ-012 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-013 In IDLE with memreq_ready=1, SHALL capture addr, write_enable, write_data and width into internal registers; go to WAIT with counter = LATENCY-1, or to RESP directly if LATENCY=1.
REQ-014 In WAIT, SHALL decrement the counter each cycle; at 0, go to RESP.
REQ-015 On the RESP transition, SHALL perform the access; in RESP, memresp_valid=1 for exactly one cycle, then return to IDLE.
REQ-016 Response timing: memresp_valid SHALL rise exactly LATENCY cycles after the accepting edge.
REQ-017 SHALL ignore memreq_ready outside IDLE; there is no queueing, and the initiator holds until the response.
REQ-018 A request SHALL be accepted in the IDLE cycle right after RESP (back-to-back throughput = LATENCY+1 cycles).
REQ-019 Width codes: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-020 Stores SHALL use 000/001/010 only; byte lanes are selected by addr[1:0]; unselected lanes are unchanged.
REQ-021 Load lanes SHALL be extracted by addr[1:0] and shifted to bit 0; sign- or zero-extended per code.
REQ-022 Store response: memresp_data_out=0, memresp_valid still pulses.
REQ-023 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; upper bits are ignored (wrap-around).
REQ-024 Misaligned access (half with addr[0]=1; word with addr[1:0]!=0) SHALL suppress the store and return load data 0.
REQ-025 Illegal codes (011, 110, 111) SHALL suppress the store and return load data 0.
REQ-026 memresp_data_out SHALL be 0 whenever memresp_valid=0.

Reset
REQ-027 reset=0 at a clock edge SHALL force IDLE, clear the counter, and set memresp_valid=0 and memresp_data_out=0.
REQ-028 Reset during WAIT SHALL abort the pending request with no write performed; reset in the RESP-entry cycle SHALL likewise suppress the write.
REQ-029 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro DMEM_ACCESS_ERR_EN defined: SHALL add output memresp_err (1 bit); it is 1 with memresp_valid for misaligned, illegal-code, or out-of-range (address >= DEPTH_WORDS*4) accesses.
REQ-031 With DMEM_ACCESS_ERR_EN, out-of-range stores SHALL be suppressed and loads SHALL return 0.
REQ-032 Macro DMEM_ACCESS_ERR_EN undefined: SHALL have no memresp_err port; out-of-range addresses wrap per REQ-023; REQ-024/025 behaviour is unchanged.

Structure
REQ-033 Width-code constants and FSM state encodings SHALL live in the shared memory-definitions include, also used by the core's memory stage.
REQ-034 Lane steering and extension SHALL be one combinational sub-module, dmem_lane_align: store byte-enables plus shifted data; load extract plus extend.
REQ-035 Storage SHALL be a single register array of DEPTH_WORDS x 32 inside dmem_responder.

Verification
REQ-036 Store-then-load word: SW 0xDEADBEEF @0x10, then LW @0x10 -> memresp_valid after LATENCY cycles each; load data 0xDEADBEEF.
REQ-037 Byte lanes: SB 0x80 @0x13 over the 0xDEADBEEF word, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-038 Misaligned: SH 0x1234 @0x11 -> word at 0x10 unchanged; LH @0x11 -> 0; with DMEM_ACCESS_ERR_EN, memresp_err=1 on both.
REQ-039 Latency/throughput: LATENCY=3, memreq_ready held high -> memresp_valid pulses every 4 cycles; requests during WAIT are not double-accepted.
REQ-040 Reset mid-operation: SW 0x55 @0x20, LATENCY=3, reset asserted in the 2nd WAIT cycle -> no memresp_valid, and a later LW @0x20 returns the old value.
REQ-041 Wrap: DEPTH_WORDS=1024, SW 0xA5A5A5A5 @0x1000 -> LW @0x0 returns 0xA5A5A5A5 (macro off); with macro on -> store suppressed and memresp_err=1.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared memory definitions: width codes, responder FSM states.
// Also imported by the core's memory stage.
package dmem_responder_pkg;

  localparam logic [2:0] MW_B  = 3'b000;
  localparam logic [2:0] MW_H  = 3'b001;
  localparam logic [2:0] MW_W  = 3'b010;
  localparam logic [2:0] MW_BU = 3'b100;
  localparam logic [2:0] MW_HU = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [2:0]  width;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering: store enables/shift, load extract/extend.
// ok=0 flags misaligned or illegal width codes.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  width,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] st_word,
  output logic [31:0] ld_data,
  output logic        ok
);

  logic [15:0] rd_lo;

  assign rd_lo   = 16'(rd_word >> {off, 3'b000});
  assign st_word = st_data << {off, 3'b000};

  // decode width code into lane enables and load result
  always_comb begin
    ok      = 1'b0;
    byte_en = '0;
    ld_data = '0;
    unique case (width)
      MW_B: begin
        ok      = 1'b1;
        byte_en = 4'b0001 << off;
        ld_data = {{24{rd_lo[7]}}, rd_lo[7:0]};
      end
      MW_BU: begin
        ok      = 1'b1;
        ld_data = {24'b0, rd_lo[7:0]};
      end
      MW_H: begin
        ok      = ~off[0];
        byte_en = 4'b0011 << off;
        ld_data = {{16{rd_lo[15]}}, rd_lo};
      end
      MW_HU: begin
        ok      = ~off[0];
        ld_data = {16'b0, rd_lo};
      end
      MW_W: begin
        ok      = (off == 2'b00);
        byte_en = 4'b1111;
        ld_data = rd_word;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      byte_en = '0;
      ld_data = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency single-outstanding access.
// Optional DMEM_ACCESS_ERR_EN adds memresp_err and range checking.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memreq_addr,
  input  logic        memreq_write_enable,
  input  logic [31:0] memreq_write_data,
  input  logic [2:0]  memreq_data_width,
  input  logic        memreq_ready,
  output logic [31:0] memresp_data_out,
  output logic        memresp_valid
`ifdef DMEM_ACCESS_ERR_EN
  ,
  output logic        memresp_err
`endif
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(LATENCY - 1);

  dmem_state_e      state;
  logic [CNT_W-1:0] cnt;
  dmem_req_t        req;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IW-1:0] idx;
  logic [31:0]   rd_word;
  logic [3:0]    byte_en;
  logic [31:0]   st_word;
  logic [31:0]   ld_data;
  logic          ok;
  logic          oor;
  logic          do_wr;

  assign idx     = req.addr[IW+1:2];
  assign rd_word = mem[idx];

`ifdef DMEM_ACCESS_ERR_EN
  assign oor = |(req.addr >> (IW + 2));
`else
  logic unused_hi;
  assign oor       = 1'b0;
  assign unused_hi = &{1'b0, req.addr[31:IW+2]};
`endif

  dmem_lane_align u_align (
    .off     (req.addr[1:0]),
    .width   (req.width),
    .st_data (req.wdata),
    .rd_word (rd_word),
    .byte_en (byte_en),
    .st_word (st_word),
    .ld_data (ld_data),
    .ok      (ok)
  );

  assign do_wr = reset && (state == ST_RESP)
              && req.we && !oor;

  // request FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      memresp_valid    <= 1'b0;
      memresp_data_out <= '0;
`ifdef DMEM_ACCESS_ERR_EN
      memresp_err      <= 1'b0;
`endif
    end else begin
      memresp_valid    <= 1'b0;
      memresp_data_out <= '0;
`ifdef DMEM_ACCESS_ERR_EN
      memresp_err      <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (memreq_ready) begin
            req.addr  <= memreq_addr;
            req.we    <= memreq_write_enable;
            req.wdata <= memreq_write_data;
            req.width <= memreq_data_width;
            cnt       <= CNT_INIT;
            state     <= (LATENCY == 1) ? ST_RESP
                                        : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= ST_RESP;
        end
        ST_RESP: begin
          memresp_valid <= 1'b1;
          if (!req.we && ok && !oor)
            memresp_data_out <= ld_data;
`ifdef DMEM_ACCESS_ERR_EN
          memresp_err <= !ok || oor
                      || (req.we && req.width[2]);
`endif
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // storage write, lane-masked; contents survive reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i])
          mem[idx][8*i +: 8] <= st_word[8*i +: 8];
      end
    end
  end

endmodule
